mem_wb_pipe: RTL and testbench

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

---
 rtl/mem_wb_pipe.sv | 134 +++++++++++++
 tb/tb_mem_wb_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with a one-entry skid buffer.
// Holds up to two results (main drives out_*, skid holds the younger one),
// so in_ready depends only on local state and never on out_ready.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   flush                    discard all buffered entries
//   in_valid / in_ready      MEM-side handshake (in_ready = !skid_valid)
//   in_wd/in_wdata/in_wreg   GPR write address, data, enable
//   in_hi/in_lo/in_whilo     HI/LO data and write enable
//   out_valid / out_ready    WB-side handshake
//   out_*                    registered WB payload; enables forced 0 when not valid
//   occupancy                number of valid entries held (0..2)
module mem_wb_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_wd,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic              in_wreg,
   input  logic [DATA_W-1:0] in_hi,
   input  logic [DATA_W-1:0] in_lo,
   input  logic              in_whilo,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_wd,
   output logic [DATA_W-1:0] out_wdata,
   output logic              out_wreg,
   output logic [DATA_W-1:0] out_hi,
   output logic [DATA_W-1:0] out_lo,
   output logic              out_whilo,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic [ADDR_W-1:0] wd;
      logic [DATA_W-1:0] wdata;
      logic              wreg;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic              whilo;
   } entry_t;

   entry_t     main_q, main_d;
   entry_t     skid_q, skid_d;
   logic       main_valid_q, main_valid_d;
   logic       skid_valid_q, skid_valid_d;
   logic [1:0] occ_q, occ_d;

   entry_t     in_entry;
   logic       accept;
   logic       consume;

   // Next-state: flush wins, then skid->main transfer, then load main or skid.
   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      occ_d        = occ_q;

      in_entry.wd    = in_wd;
      in_entry.wdata = in_wdata;
      in_entry.wreg  = in_wreg;
      in_entry.hi    = in_hi;
      in_entry.lo    = in_lo;
      in_entry.whilo = in_whilo;

      consume = main_valid_q & out_ready;
      // Entries presented during flush are ignored even if in_ready is high.
      accept  = in_valid & ~skid_valid_q & ~flush;

      if (flush) begin
         main_d       = '0;
         main_valid_d = 1'b0;
         skid_d       = '0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // in_ready is low here, so no new entry competes with the transfer.
         if (consume) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end
      end else if (!main_valid_q || consume) begin
         if (accept) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
         end else begin
            // Going empty: drop write enables so WB never sees a stale write.
            main_valid_d = 1'b0;
            main_d.wreg  = 1'b0;
            main_d.whilo = 1'b0;
         end
      end else if (accept) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end

      occ_d = 2'(main_valid_d) + 2'(skid_valid_d);
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         occ_q        <= 2'd0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         occ_q        <= occ_d;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_wd    = main_q.wd;
   assign out_wdata = main_q.wdata;
   assign out_wreg  = main_q.wreg;
   assign out_hi    = main_q.hi;
   assign out_lo    = main_q.lo;
   assign out_whilo = main_q.whilo;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe (DATA_W=64, ADDR_W=5).
module tb_mem_wb_pipe;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_wd;
   logic [DATA_W-1:0] in_wdata;
   logic              in_wreg;
   logic [DATA_W-1:0] in_hi;
   logic [DATA_W-1:0] in_lo;
   logic              in_whilo;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_wd;
   logic [DATA_W-1:0] out_wdata;
   logic              out_wreg;
   logic [DATA_W-1:0] out_hi;
   logic [DATA_W-1:0] out_lo;
   logic              out_whilo;
   logic [1:0]        occupancy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wd(in_wd), .in_wdata(in_wdata), .in_wreg(in_wreg),
      .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_wd(out_wd), .out_wdata(out_wdata), .out_wreg(out_wreg),
      .out_hi(out_hi), .out_lo(out_lo), .out_whilo(out_whilo),
      .occupancy(occupancy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [4:0] wd, input logic [63:0] wdata,
                      input logic wreg);
      in_valid = v;
      in_wd    = wd;
      in_wdata = wdata;
      in_wreg  = wreg;
      in_hi    = '0;
      in_lo    = '0;
      in_whilo = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      put(1'b0, 5'd0, 64'd0, 1'b0);
      tick(); tick();

      // Reset state
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_out_wd", 64'(out_wd), 64'd0);
      chk("rst_out_wreg", 64'(out_wreg), 64'd0);
      rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Single entry, 1-cycle latency
      out_ready = 1'b1;
      put(1'b1, 5'd5, 64'h1234, 1'b1);
      tick();
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_wd", 64'(out_wd), 64'd5);
      chk("t1_out_wdata", out_wdata, 64'h1234);
      chk("t1_out_wreg", 64'(out_wreg), 64'd1);
      chk("t1_occ", 64'(occupancy), 64'd1);
      put(1'b0, 5'd0, 64'd0, 1'b0);
      tick();
      chk("t1_drain_valid", 64'(out_valid), 64'd0);
      chk("t1_drain_wreg", 64'(out_wreg), 64'd0);
      chk("t1_drain_occ", 64'(occupancy), 64'd0);

      // Backpressure: A then B fill main and skid
      out_ready = 1'b0;
      put(1'b1, 5'd1, 64'hA1, 1'b1);
      tick();
      chk("t2_a_occ", 64'(occupancy), 64'd1);
      chk("t2_a_in_ready", 64'(in_ready), 64'd1);
      put(1'b1, 5'd2, 64'hB2, 1'b1);
      tick();
      chk("t2_full_occ", 64'(occupancy), 64'd2);
      chk("t2_full_in_ready", 64'(in_ready), 64'd0);
      chk("t2_full_wdata", out_wdata, 64'hA1);
      chk("t2_full_wd", 64'(out_wd), 64'd1);
      // C offered while full: must be dropped, A held stable
      put(1'b1, 5'd3, 64'hC3, 1'b1);
      tick();
      chk("t2_hold_occ", 64'(occupancy), 64'd2);
      chk("t2_hold_wdata", out_wdata, 64'hA1);
      // Consume A while C still offered: B moves up, C dropped
      out_ready = 1'b1;
      tick();
      chk("t2_b_wdata", out_wdata, 64'hB2);
      chk("t2_b_wd", 64'(out_wd), 64'd2);
      chk("t2_b_occ", 64'(occupancy), 64'd1);
      chk("t2_b_in_ready", 64'(in_ready), 64'd1);
      put(1'b0, 5'd0, 64'd0, 1'b0);
      tick();
      chk("t2_c_dropped", 64'(out_valid), 64'd0);
      chk("t2_end_occ", 64'(occupancy), 64'd0);

      // Streaming: one entry per cycle, no bubbles
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         put(1'b1, 5'(i + 8), 64'(i), 1'b1);
         tick();
         chk($sformatf("t3_wdata_%0d", i), out_wdata, 64'(i));
         chk($sformatf("t3_valid_%0d", i), 64'(out_valid), 64'd1);
         chk($sformatf("t3_occ_%0d", i), 64'(occupancy), 64'd1);
      end
      put(1'b0, 5'd0, 64'd0, 1'b0);
      tick();
      chk("t3_end_valid", 64'(out_valid), 64'd0);

      // Flush with both entries held and a new entry offered
      out_ready = 1'b0;
      put(1'b1, 5'd4, 64'h44, 1'b1);
      in_whilo = 1'b1;
      tick();
      put(1'b1, 5'd6, 64'h66, 1'b1);
      tick();
      chk("t4_pre_occ", 64'(occupancy), 64'd2);
      flush = 1'b1; out_ready = 1'b1;
      put(1'b1, 5'd7, 64'hDD, 1'b1);
      tick();
      chk("t4_valid", 64'(out_valid), 64'd0);
      chk("t4_wreg", 64'(out_wreg), 64'd0);
      chk("t4_whilo", 64'(out_whilo), 64'd0);
      chk("t4_occ", 64'(occupancy), 64'd0);
      chk("t4_wd", 64'(out_wd), 64'd0);
      chk("t4_wdata", out_wdata, 64'd0);
      // Flush from empty with in_ready=1: offered entry still ignored
      tick();
      chk("t4_empty_flush_valid", 64'(out_valid), 64'd0);
      flush = 1'b0;
      put(1'b0, 5'd0, 64'd0, 1'b0);
      tick();
      chk("t4_never_appears", 64'(out_valid), 64'd0);
      chk("t4_end_occ", 64'(occupancy), 64'd0);

      // Full-width HI/LO pass-through and hold stability
      out_ready = 1'b0;
      put(1'b1, 5'd31, 64'hFFFF_0000_1234_5678, 1'b0);
      in_hi = 64'hAAAA5555_AAAA5555;
      in_lo = 64'h0F0F0F0F_0F0F0F0F;
      in_whilo = 1'b1;
      tick();
      chk("t5_hi", out_hi, 64'hAAAA5555_AAAA5555);
      chk("t5_lo", out_lo, 64'h0F0F0F0F_0F0F0F0F);
      chk("t5_whilo", 64'(out_whilo), 64'd1);
      chk("t5_wreg", 64'(out_wreg), 64'd0);
      chk("t5_wd", 64'(out_wd), 64'd31);
      put(1'b0, 5'd0, 64'd0, 1'b0);
      tick();
      chk("t5_hold_hi", out_hi, 64'hAAAA5555_AAAA5555);
      chk("t5_hold_wdata", out_wdata, 64'hFFFF_0000_1234_5678);
      chk("t5_hold_whilo", 64'(out_whilo), 64'd1);
      out_ready = 1'b1;
      tick();
      chk("t5_drain_whilo", 64'(out_whilo), 64'd0);

      // Reset beats flush/in_valid/out_ready with both entries held
      out_ready = 1'b0;
      put(1'b1, 5'd9, 64'h99, 1'b1);
      tick();
      put(1'b1, 5'd10, 64'hAA, 1'b1);
      tick();
      chk("t6_pre_occ", 64'(occupancy), 64'd2);
      rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
      put(1'b1, 5'd11, 64'hBB, 1'b1);
      in_whilo = 1'b1;
      tick();
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_occ", 64'(occupancy), 64'd0);
      chk("t6_wd", 64'(out_wd), 64'd0);
      chk("t6_wdata", out_wdata, 64'd0);
      chk("t6_hi", out_hi, 64'd0);
      chk("t6_lo", out_lo, 64'd0);
      chk("t6_wreg", 64'(out_wreg), 64'd0);
      chk("t6_whilo", 64'(out_whilo), 64'd0);
      rst = 1'b0; flush = 1'b0;
      put(1'b0, 5'd0, 64'd0, 1'b0);
      chk("t6_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("t6_after_valid", 64'(out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
